// File: rtl/arb_rr_ctrl_if.sv
// Request/grant bundle for the round-robin arbiter.
// The slave side belongs to the arbiter; the master side belongs to whoever drives the requests.
interface arb_rr_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]         v_req;
    logic [WIDTH-1:0]         v_release;
    logic [WIDTH-1:0]         v_grant;
    logic                     grant_vld;
    logic [$clog2(WIDTH)-1:0] grant_idx;
    logic [WIDTH-1:0]         v_priority;
    logic                     timeout;

    modport slave (
        input  v_req,
        input  v_release,
        output v_grant,
        output grant_vld,
        output grant_idx,
        output v_priority,
        output timeout
    );

    modport master (
        output v_req,
        output v_release,
        input  v_grant,
        input  grant_vld,
        input  grant_idx,
        input  v_priority,
        input  timeout
    );
endinterface

// File: rtl/arb_rr_ctrl.sv
// Round-robin arbiter with a locked grant, bounded hold time and back-to-back handover.
// The priority pointer moves only when a grant ends, and then points one above the
// requester that just finished.
module arb_rr_ctrl #(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_rr_ctrl_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [WIDTH-1:0] grant_q;
    logic [WIDTH-1:0] prio_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    hold_cnt;
    logic             timeout_q;

    logic [IW-1:0]    prio_idx;
    logic [IW-1:0]    nxt_idx;
    logic [IW-1:0]    base_idx;
    logic [IW-1:0]    win_idx;
    logic [WIDTH-1:0] win_oh;
    logic [WIDTH-1:0] prio_rot;
    logic             found;
    logic             rel_hit;
    logic             at_limit;
    int unsigned      pos;

    assign nxt_idx  = (idx_q == IW'(WIDTH - 1)) ? '0 : idx_q + 1'b1;
    assign prio_rot = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
    assign rel_hit  = bus.v_release[idx_q];
    assign at_limit = (hold_cnt == HOLD_LIM);

    // Encode the one-hot priority pointer into a binary start position.
    always_comb begin
        prio_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (prio_q[i]) prio_idx = IW'(i);
        end
    end

    // Circular first-set search; while busy the search is only consumed at grant end,
    // so it always starts from the rotated pointer (one above the current owner).
    always_comb begin
        base_idx = (state == BUSY) ? nxt_idx : prio_idx;
        found    = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        pos      = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pos = 32'(base_idx) + i;
            if (pos >= WIDTH) pos = pos - WIDTH;
            if (!found && bus.v_req[IW'(pos)]) begin
                found   = 1'b1;
                win_idx = IW'(pos);
            end
        end
        if (found) win_oh[win_idx] = 1'b1;
    end

    // Two-state controller holding grant, pointer, hold counter and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            prio_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
            idx_q     <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= BUSY;
                        grant_q  <= win_oh;
                        idx_q    <= win_idx;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (rel_hit || at_limit) begin
                        timeout_q <= !rel_hit;
                        prio_q    <= prio_rot;
                        hold_cnt  <= '0;
                        if (found) begin
                            grant_q <= win_oh;
                            idx_q   <= win_idx;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                            idx_q   <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.v_grant    = grant_q;
    assign bus.grant_vld  = (state == BUSY);
    assign bus.grant_idx  = idx_q;
    assign bus.v_priority = prio_q;
    assign bus.timeout    = timeout_q;
endmodule
